// File: rtl/otp_decryptor.sv
// One-time-pad receive block: single-use pad table plus a one-entry skid-free output register.
// Optional OTP_ERR_CNT_EN adds a saturating count of pad-miss results on port err_cnt.
module otp_decryptor #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pad_wr_en,
   input  logic [IDX_W-1:0]  pad_wr_idx,
   input  logic [DATA_W-1:0] pad_wr_data,
   input  logic              ct_valid,
   output logic              ct_ready,
   input  logic [DATA_W-1:0] ct_data,
   input  logic [IDX_W-1:0]  ct_idx,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [DATA_W-1:0] pt_data,
   output logic [IDX_W-1:0]  pt_idx,
   output logic              pt_err,
   output logic [DEPTH-1:0]  pad_avail
`ifdef OTP_ERR_CNT_EN
  ,output logic [7:0]        err_cnt
`endif
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                        state_q, state_d;
   logic [DEPTH-1:0][DATA_W-1:0]  pad_q;
   logic [DEPTH-1:0]              valid_q, valid_d;
   logic [DATA_W-1:0]             pt_data_q, pt_data_d;
   logic [IDX_W-1:0]              pt_idx_q, pt_idx_d;
   logic                          pt_err_q, pt_err_d;
   logic                          accept, hit;

   assign ct_ready  = (state_q == EMPTY) | pt_ready;
   assign accept    = ct_valid & ct_ready;
   assign hit       = valid_q[ct_idx];
   assign pt_valid  = (state_q == FULL);
   assign pt_data   = pt_data_q;
   assign pt_idx    = pt_idx_q;
   assign pt_err    = pt_err_q;
   assign pad_avail = valid_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (pt_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Consume clears before the write sets, so a same-index write leaves the entry loaded.
   always_comb begin
      valid_d   = valid_q;
      pt_data_d = pt_data_q;
      pt_idx_d  = pt_idx_q;
      pt_err_d  = pt_err_q;
      if (accept) begin
         pt_idx_d = ct_idx;
         if (hit) begin
            pt_data_d       = ct_data ^ pad_q[ct_idx];
            pt_err_d        = 1'b0;
            valid_d[ct_idx] = 1'b0;
         end else begin
            pt_data_d = '0;
            pt_err_d  = 1'b1;
         end
      end
      if (pad_wr_en) valid_d[pad_wr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         valid_q   <= '0;
         pt_data_q <= '0;
         pt_idx_q  <= '0;
         pt_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         pt_data_q <= pt_data_d;
         pt_idx_q  <= pt_idx_d;
         pt_err_q  <= pt_err_d;
      end
   end

   // Pad storage is gated by the valid bits, so it is never cleared.
   always_ff @(posedge clk) begin
      if (pad_wr_en) pad_q[pad_wr_idx] <= pad_wr_data;
   end

`ifdef OTP_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && !hit && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_otp_decryptor.sv
// Scoreboard bench for otp_decryptor: directed scenarios plus randomized traffic.
module tb_otp_decryptor;
   localparam int DW = 8, D = 8, IW = 3;

   logic          clk = 1'b0;
   logic          rst_n, pad_wr_en, ct_valid, pt_ready;
   logic [IW-1:0] pad_wr_idx, ct_idx, pt_idx;
   logic [DW-1:0] pad_wr_data, ct_data, pt_data;
   logic          ct_ready, pt_valid, pt_err;
   logic [D-1:0]  pad_avail;
`ifdef OTP_ERR_CNT_EN
   logic [7:0]    err_cnt;
`endif

   always #5 clk = ~clk;

   otp_decryptor #(.DATA_W(DW), .DEPTH(D), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .pad_wr_en(pad_wr_en), .pad_wr_idx(pad_wr_idx),
      .pad_wr_data(pad_wr_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
      .ct_data(ct_data), .ct_idx(ct_idx), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_data(pt_data), .pt_idx(pt_idx), .pt_err(pt_err), .pad_avail(pad_avail)
`ifdef OTP_ERR_CNT_EN
     ,.err_cnt(err_cnt)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [IW-1:0] i;
      logic          e;
   } res_t;

   res_t          q[$];
   logic [DW-1:0] m_pad[D];
   bit            m_vld[D];
   bit            m_full;
   int            m_ecnt;
   bit            chk_en = 1'b0;
   int            n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pad_wr_en = 0; ct_valid = 0;
   endtask

   // Reference model and monitor: inputs are stable at the falling edge, so this
   // checks what the last rising edge produced and predicts the next one.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            logic [D-1:0] av;
            for (int k = 0; k < D; k++) av[k] = m_vld[k];
            chk("pt_valid", pt_valid, m_full);
            chk("ct_ready", ct_ready, (!m_full || pt_ready));
            chk("pad_avail", pad_avail, av);
`ifdef OTP_ERR_CNT_EN
            chk("err_cnt", err_cnt, m_ecnt);
`endif
            if (m_full && pt_valid) begin
               if (q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL sb_empty: got pt_valid=1 expected a queued result");
               end else begin
                  chk("sb_pt_data", pt_data, q[0].d);
                  chk("sb_pt_idx", pt_idx, q[0].i);
                  chk("sb_pt_err", pt_err, q[0].e);
               end
            end
            if (m_full && pt_ready && q.size() != 0) void'(q.pop_front());
         end
         if (!rst_n) begin
            for (int k = 0; k < D; k++) m_vld[k] = 0;
            m_full = 0; m_ecnt = 0; q.delete();
            chk_en = 1;
         end else begin
            bit acc;
            acc = ct_valid && (!m_full || pt_ready);
            if (acc) begin
               if (m_vld[ct_idx]) begin
                  q.push_back('{d: ct_data ^ m_pad[ct_idx], i: ct_idx, e: 1'b0});
                  m_vld[ct_idx] = 0;
               end else begin
                  q.push_back('{d: 8'h00, i: ct_idx, e: 1'b1});
                  if (m_ecnt < 255) m_ecnt++;
               end
            end
            if (pad_wr_en) begin
               m_pad[pad_wr_idx] = pad_wr_data;
               m_vld[pad_wr_idx] = 1;
            end
            if (acc) m_full = 1;
            else if (pt_ready) m_full = 0;
         end
      end
   end

   initial begin
      rst_n = 0; pt_ready = 1; pad_wr_idx = 0; pad_wr_data = 0; ct_data = 0; ct_idx = 0;
      idle();
      cyc(); cyc();
      chk("rst_pt_valid", pt_valid, 0);
      chk("rst_pad_avail", pad_avail, 0);
      chk("rst_pt_data", pt_data, 0);
      chk("rst_pt_idx", pt_idx, 0);
      chk("rst_pt_err", pt_err, 0);
      rst_n = 1;

      // basic decrypt, then reuse of a consumed pad
      pad_wr_en = 1; pad_wr_idx = 3; pad_wr_data = 8'hA5; cyc();
      pad_wr_en = 0; ct_valid = 1; ct_data = 8'h5A; ct_idx = 3; cyc();
      ct_valid = 0;
      chk("t1_valid", pt_valid, 1);
      chk("t1_data", pt_data, 8'hFF);
      chk("t1_idx", pt_idx, 3);
      chk("t1_err", pt_err, 0);
      chk("t1_avail3", pad_avail[3], 0);
      ct_valid = 1; cyc(); ct_valid = 0;
      chk("t2_data", pt_data, 8'h00);
      chk("t2_err", pt_err, 1);
`ifdef OTP_ERR_CNT_EN
      chk("t2_err_cnt", err_cnt, 1);
`endif

      // full-table stream, one result per cycle
      for (int i = 0; i < D; i++) begin
         pad_wr_en = 1; pad_wr_idx = IW'(i); pad_wr_data = 8'h10 + 8'(i); cyc();
      end
      pad_wr_en = 0;
      for (int i = 0; i < D; i++) begin
         ct_valid = 1; ct_data = 8'(i); ct_idx = IW'(i); cyc();
         chk("t3_valid", pt_valid, 1);
         chk("t3_data", pt_data, 8'(i) ^ (8'h10 + 8'(i)));
      end
      ct_valid = 0;
      chk("t3_avail", pad_avail, 0);

      // backpressure: result held, second byte waits, then no bubble
      pad_wr_en = 1; pad_wr_idx = 0; pad_wr_data = 8'h40; cyc();
      pad_wr_idx = 1; pad_wr_data = 8'h41; cyc();
      pad_wr_en = 0; pt_ready = 0; ct_valid = 1; ct_data = 8'h01; ct_idx = 0; cyc();
      ct_data = 8'h02; ct_idx = 1; cyc();
      chk("t4_ready_lo", ct_ready, 0);
      chk("t4_hold_data", pt_data, 8'h41);
      cyc();
      chk("t4_hold_data2", pt_data, 8'h41);
      chk("t4_hold_idx", pt_idx, 0);
      pt_ready = 1; #1;
      chk("t4_ready_hi", ct_ready, 1);
      cyc(); ct_valid = 0;
      chk("t4_second", pt_data, 8'h43);
      chk("t4_second_idx", pt_idx, 1);
      cyc();
      chk("t4_drained", pt_valid, 0);

      // same-cycle write and consume of one index
      pad_wr_en = 1; pad_wr_idx = 2; pad_wr_data = 8'h11; cyc();
      pad_wr_data = 8'h33; ct_valid = 1; ct_data = 8'h00; ct_idx = 2; cyc();
      pad_wr_en = 0;
      chk("t5_old_pad", pt_data, 8'h11);
      chk("t5_err", pt_err, 0);
      chk("t5_avail2", pad_avail[2], 1);
      cyc(); ct_valid = 0;
      chk("t5_new_pad", pt_data, 8'h33);

      // reset while FULL
      pad_wr_en = 1; pad_wr_idx = 5; pad_wr_data = 8'h5C; cyc();
      pad_wr_en = 0; pt_ready = 0; ct_valid = 1; ct_data = 8'h00; ct_idx = 5; cyc();
      ct_valid = 0;
      chk("t6_full", pt_valid, 1);
      rst_n = 0; cyc(); rst_n = 1;
      chk("t6_rst_valid", pt_valid, 0);
      chk("t6_rst_avail", pad_avail, 0);
      pt_ready = 1; ct_valid = 1; cyc(); ct_valid = 0;
      chk("t6_miss", pt_err, 1);

`ifdef OTP_ERR_CNT_EN
      rst_n = 0; cyc(); rst_n = 1;
      ct_valid = 1; ct_idx = 0;
      for (int i = 0; i < 260; i++) cyc();
      ct_valid = 0;
      chk("err_cnt_sat", err_cnt, 8'hFF);
`endif

      for (int i = 0; i < 2000; i++) begin
         rst_n       = ($urandom % 300) != 0;
         pad_wr_en   = ($urandom % 3) == 0;
         pad_wr_idx  = IW'($urandom);
         pad_wr_data = DW'($urandom);
         ct_valid    = ($urandom % 2) == 0;
         ct_data     = DW'($urandom);
         ct_idx      = IW'($urandom);
         pt_ready    = ($urandom % 4) != 0;
         cyc();
      end

      rst_n = 1; idle(); pt_ready = 1;
      cyc(); cyc(); cyc();
      chk("sb_drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
